// File: rtl/ni_injector_pkg.sv
// Flit format for the NoC local port: flit type encoding, field offsets/widths,
// the 80-bit flit_t layout, the injector FSM state type and the HEAD payload helper.
// Shared by ni_injector_if, ni_vc_credit and ni_injector.
package ni_injector_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int FLIT_WIDTH = 80;

    // field offsets/widths inside a flit
    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam int HOP_LSB  = 2;
    localparam int HOP_W    = 5;
    localparam int DSTX_LSB = 7;
    localparam int DSTX_W   = 2;
    localparam int DSTY_LSB = 9;
    localparam int DSTY_W   = 2;
    localparam int VC_LSB   = 11;
    localparam int VC_W     = 5;
    localparam int DATA_LSB = 16;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_IDLE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    // MSB first: data occupies [79:16], type occupies [1:0]
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [VC_W-1:0]       vc;
        logic [DSTY_W-1:0]     dst_y;
        logic [DSTX_W-1:0]     dst_x;
        logic [HOP_W-1:0]      nxt_hop;
        flit_type_e            ftype;
    } flit_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } inj_state_e;

    // HEAD payload: source coordinates plus a word count of 0 (length unknown up front)
    function automatic logic [DATA_WIDTH-1:0] head_data(input logic [1:0] src_y,
                                                        input logic [1:0] src_x);
        return {44'b0, src_y, src_x, 16'b0};
    endfunction

endpackage

// File: rtl/ni_injector_if.sv
// Message-word stream into the injector (valid/ready handshake).
// master: word source (drives valid/data/last/dst, samples ready).
// slave:  injector (samples the word, drives ready).
interface ni_injector_if;
    import ni_injector_pkg::*;

    logic                  msg_valid;
    logic                  msg_ready;
    logic [DATA_WIDTH-1:0] msg_data;
    logic                  msg_last;
    logic [1:0]            msg_dst_x;
    logic [1:0]            msg_dst_y;

    modport master (
        output msg_valid, msg_data, msg_last, msg_dst_x, msg_dst_y,
        input  msg_ready
    );

    modport slave (
        input  msg_valid, msg_data, msg_last, msg_dst_x, msg_dst_y,
        output msg_ready
    );

endinterface

// File: rtl/ni_vc_credit.sv
// Per-VC credit counters for the router local input buffers, VC eligibility and
// round-robin VC picker. Ports: clk/rst, vc_busy_in/credit_in from the router,
// send/send_vc (flit leaving on a VC), done (packet finished, advance RR), can_send/pick outputs.
module ni_vc_credit
    import ni_injector_pkg::*;
#(
    parameter int VC_NUM    = 5,
    parameter int BUF_DEPTH = 4,
    localparam int CW       = $clog2(BUF_DEPTH + 1),
    localparam int VCW      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VC_NUM-1:0] vc_busy_in,
    input  logic [VC_NUM-1:0] credit_in,
    input  logic              send,
    input  logic [VCW-1:0]    send_vc,
    input  logic              done,
    output logic [VC_NUM-1:0] can_send,
    output logic              pick_vld,
    output logic [VCW-1:0]    pick_vc
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    logic [VC_NUM-1:0][CW-1:0] credit;
    logic [VC_NUM-1:0]         dec;
    logic [VC_NUM-1:0]         elig;
    logic [VCW-1:0]            rr_ptr;

    always_comb begin
        dec      = '0;
        can_send = '0;
        elig     = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            dec[v]      = send && (send_vc == VCW'(v));
            can_send[v] = (credit[v] != '0) && !vc_busy_in[v];
            // a new packet only starts on a VC whose router buffer is completely drained
            elig[v]     = (credit[v] == FULL) && !vc_busy_in[v];
        end
    end

    // return and spend in the same cycle cancel; a return at FULL is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) credit[v] <= FULL;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (credit_in[v] && !dec[v] && (credit[v] != FULL))
                    credit[v] <= credit[v] + 1'b1;
                else if (dec[v] && !credit_in[v])
                    credit[v] <= credit[v] - 1'b1;
            end
        end
    end

    // scan from the highest offset down so the first eligible VC at/after rr_ptr wins
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_vc  = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % VC_NUM;
            if (elig[idx]) begin
                pick_vld = 1'b1;
                pick_vc  = VCW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (done)
            rr_ptr <= (send_vc == VCW'(VC_NUM - 1)) ? '0 : send_vc + 1'b1;
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_ovf
        a_credit_ovf: assert property (@(posedge clk) disable iff (rst)
            !(credit_in[v] && !dec[v] && (credit[v] == FULL)));
    end

endmodule

// File: rtl/ni_injector.sv
// NI injection stage: message words -> HEAD/BODY/TAIL flits on a credited, round-robin VC.
// Ports: clk/rst, id_x/id_y, msg (slave stream), vc_busy_in, credit_in, flit_out (registered).
// NI_INJ_STATS_EN adds pkt_cnt/flit_cnt outputs (packets = TAILs, flits = all emitted flits).
module ni_injector
    import ni_injector_pkg::*;
#(
    parameter int x_size     = 4,
    parameter int y_size     = 4,
    parameter int VC_NUM     = 5,
    parameter int BUF_DEPTH  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FLIT_WIDTH = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            id_x,
    input  logic [1:0]            id_y,
    ni_injector_if.slave          msg,
    input  logic [VC_NUM-1:0]     vc_busy_in,
    input  logic [VC_NUM-1:0]     credit_in,
    output logic [FLIT_WIDTH-1:0] flit_out
`ifdef NI_INJ_STATS_EN
    ,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           flit_cnt
`endif
);

    localparam int DXW = (x_size > 1) ? $clog2(x_size) : 1;
    localparam int DYW = (y_size > 1) ? $clog2(y_size) : 1;
    localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    inj_state_e            state_q, state_d;
    logic [VCW-1:0]        vc_q;
    logic [DXW-1:0]        dst_x_q;
    logic [DYW-1:0]        dst_y_q;
    flit_t                 flit_q, flit_d;
    logic [VC_W-1:0]       vc_oh;
    logic [DATA_WIDTH-1:0] word;
    logic                  rdy, can, send, done, latch;
    logic [VC_NUM-1:0]     can_send;
    logic                  pick_vld;
    logic [VCW-1:0]        pick_vc;

    ni_vc_credit #(
        .VC_NUM    (VC_NUM),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .vc_busy_in (vc_busy_in),
        .credit_in  (credit_in),
        .send       (send),
        .send_vc    (vc_q),
        .done       (done),
        .can_send   (can_send),
        .pick_vld   (pick_vld),
        .pick_vc    (pick_vc)
    );

    assign word          = msg.msg_data;
    assign msg.msg_ready = rdy;
    assign flit_out      = flit_q;

    always_comb begin
        vc_oh = '0;
        for (int v = 0; v < VC_NUM; v++) vc_oh[v] = (vc_q == VCW'(v));
    end

    always_comb begin
        state_d        = state_q;
        flit_d         = '0;
        rdy            = 1'b0;
        send           = 1'b0;
        done           = 1'b0;
        latch          = 1'b0;
        can            = can_send[vc_q];
        flit_d.dst_x   = DSTX_W'(dst_x_q);
        flit_d.dst_y   = DSTY_W'(dst_y_q);
        flit_d.vc      = vc_oh;
        case (state_q)
            // word is only looked at here, not consumed; it becomes the first BODY/TAIL
            S_IDLE: begin
                if (msg.msg_valid && pick_vld) begin
                    latch   = 1'b1;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (can) begin
                    send         = 1'b1;
                    flit_d.ftype = FLIT_HEAD;
                    flit_d.data  = head_data(id_y, id_x);
                    state_d      = S_BODY;
                end
            end
            S_BODY: begin
                rdy = can;
                if (msg.msg_valid && can) begin
                    send         = 1'b1;
                    flit_d.ftype = msg.msg_last ? FLIT_TAIL : FLIT_BODY;
                    flit_d.data  = word;
                    if (msg.msg_last) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // non-emitting cycles must present an all-zero (IDLE) flit, not stale routing fields
        if (!send) flit_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            flit_q  <= '0;
            vc_q    <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            if (latch) begin
                vc_q    <= pick_vc;
                dst_x_q <= msg.msg_dst_x[DXW-1:0];
                dst_y_q <= msg.msg_dst_y[DYW-1:0];
            end
        end
    end

`ifdef NI_INJ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt  <= '0;
            flit_cnt <= '0;
        end else begin
            if (send) flit_cnt <= flit_cnt + 32'd1;
            if (done) pkt_cnt  <= pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ni_injector.sv
// Cycle-by-cycle vector bench for ni_injector: each record drives one cycle of inputs and
// gives the expected msg_ready during that cycle and flit_out after its rising edge.
module tb_ni_injector;

    logic        clk;
    logic        rst;
    logic [1:0]  id_x;
    logic [1:0]  id_y;
    logic [4:0]  vc_busy_in;
    logic [4:0]  credit_in;
    logic [79:0] flit_out;
`ifdef NI_INJ_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] flit_cnt;
`endif

    ni_injector_if msg_if();

    ni_injector dut (
        .clk        (clk),
        .rst        (rst),
        .id_x       (id_x),
        .id_y       (id_y),
        .msg        (msg_if),
        .vc_busy_in (vc_busy_in),
        .credit_in  (credit_in),
        .flit_out   (flit_out)
`ifdef NI_INJ_STATS_EN
        ,
        .pkt_cnt    (pkt_cnt),
        .flit_cnt   (flit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        last;
        logic [63:0] data;
        logic [1:0]  dx;
        logic [1:0]  dy;
        logic [4:0]  busy;
        logic [4:0]  cred;
        logic        rdy;
        logic [79:0] flit;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cur    = 0;

    localparam logic [1:0]  TH  = 2'b01;
    localparam logic [1:0]  TB  = 2'b10;
    localparam logic [1:0]  TT  = 2'b11;
    localparam logic [79:0] Z80 = 80'h0;
    localparam logic [63:0] Z64 = 64'h0;
    // HEAD payload for a node at x=1, y=2
    localparam logic [63:0] HD  = {44'b0, 2'd2, 2'd1, 16'b0};

    function automatic logic [79:0] fl(input logic [1:0] t, input int dx, input int dy,
                                       input int vc, input logic [63:0] d);
        logic [4:0] oh;
        oh = 5'b00001 << vc;
        return {d, oh, 2'(dy), 2'(dx), 5'b0, t};
    endfunction

    task automatic add(input int r, input int vld, input int last, input logic [63:0] d,
                       input int dx, input int dy, input int busy, input int cred,
                       input int rdy, input logic [79:0] f);
        vec_t v;
        v.rst  = 1'(r);
        v.vld  = 1'(vld);
        v.last = 1'(last);
        v.data = d;
        v.dx   = 2'(dx);
        v.dy   = 2'(dy);
        v.busy = 5'(busy);
        v.cred = 5'(cred);
        v.rdy  = 1'(rdy);
        v.flit = f;
        vecs.push_back(v);
    endtask

    task automatic idle();
        add(0, 0, 0, Z64, 0, 0, 0, 0, 0, Z80);
    endtask

    task automatic rst_vec();
        add(1, 0, 0, Z64, 0, 0, 0, 0, 0, Z80);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %b want %b", nm, cur, got, exp);
        end
    endtask

    task automatic chk80(input string nm, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", nm, cur, got, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        msg_if.msg_valid = v.vld;
        msg_if.msg_last  = v.last;
        msg_if.msg_data  = v.data;
        msg_if.msg_dst_x = v.dx;
        msg_if.msg_dst_y = v.dy;
        vc_busy_in       = v.busy;
        credit_in        = v.cred;
        #1;
        chk1("msg_ready", msg_if.msg_ready, v.rdy);
        @(posedge clk);
        #1;
        chk80("flit_out", flit_out, v.flit);
    endtask

    task automatic run_from(input int first);
        for (int i = first; i < vecs.size(); i++) begin
            cur = i;
            step(vecs[i]);
        end
    endtask

    initial begin
        int hand_start;

        rst              = 1'b1;
        id_x             = 2'd1;
        id_y             = 2'd2;
        msg_if.msg_valid = 1'b0;
        msg_if.msg_last  = 1'b0;
        msg_if.msg_data  = Z64;
        msg_if.msg_dst_x = 2'd0;
        msg_if.msg_dst_y = 2'd0;
        vc_busy_in       = 5'b0;
        credit_in        = 5'b0;

        // single word to (2,3): HEAD then TAIL on consecutive edges, VC0
        add(0, 1, 1, 64'h1111_2222_3333_4444, 2, 3, 0, 0, 0, Z80);
        add(0, 1, 1, 64'h1111_2222_3333_4444, 2, 3, 0, 0, 0, fl(TH, 2, 3, 0, HD));
        add(0, 1, 1, 64'h1111_2222_3333_4444, 2, 3, 0, 0, 1, fl(TT, 2, 3, 0, 64'h1111_2222_3333_4444));
        idle();
        // VC0 now holds 2 credits: with VC1-4 busy nothing starts until two returns arrive
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 0, 0, Z80);
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 5'b00001, 0, Z80);
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 5'b00001, 0, Z80);
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 0, 0, Z80);
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 0, 0, fl(TH, 1, 0, 0, HD));
        add(0, 1, 1, 64'hA5A5_0000_FFFF_0001, 1, 0, 5'b11110, 0, 1, fl(TT, 1, 0, 0, 64'hA5A5_0000_FFFF_0001));
        idle();
        rst_vec();

        // 4-word message to (3,1): HEAD + 3 BODY drain the 4 credits, 4th word waits for a return
        add(0, 1, 0, 64'h0B0D_0000_0000_0000, 3, 1, 0, 0, 0, Z80);
        add(0, 1, 0, 64'h0B0D_0000_0000_0000, 3, 1, 0, 0, 0, fl(TH, 3, 1, 0, HD));
        add(0, 1, 0, 64'h0B0D_0000_0000_0000, 3, 1, 0, 0, 1, fl(TB, 3, 1, 0, 64'h0B0D_0000_0000_0000));
        add(0, 1, 0, 64'h0B0D_0000_0000_0001, 3, 1, 0, 0, 1, fl(TB, 3, 1, 0, 64'h0B0D_0000_0000_0001));
        add(0, 1, 0, 64'h0B0D_0000_0000_0002, 3, 1, 0, 0, 1, fl(TB, 3, 1, 0, 64'h0B0D_0000_0000_0002));
        add(0, 1, 1, 64'h0B0D_0000_0000_0003, 3, 1, 0, 0, 0, Z80);
        add(0, 1, 1, 64'h0B0D_0000_0000_0003, 3, 1, 0, 5'b00001, 0, Z80);
        add(0, 1, 1, 64'h0B0D_0000_0000_0003, 3, 1, 0, 0, 1, fl(TT, 3, 1, 0, 64'h0B0D_0000_0000_0003));
        idle();
        rst_vec();

        // VC0 busy at pick -> VC1; VC1 busy for 3 cycles mid-packet -> 3 zero flits, then TAIL
        add(0, 1, 0, 64'hC0DE_0000_0000_00A0, 0, 2, 5'b00001, 0, 0, Z80);
        add(0, 1, 0, 64'hC0DE_0000_0000_00A0, 0, 2, 0, 0, 0, fl(TH, 0, 2, 1, HD));
        add(0, 1, 0, 64'hC0DE_0000_0000_00A0, 0, 2, 0, 0, 1, fl(TB, 0, 2, 1, 64'hC0DE_0000_0000_00A0));
        add(0, 1, 1, 64'hC0DE_0000_0000_00A1, 0, 2, 5'b00010, 0, 0, Z80);
        add(0, 1, 1, 64'hC0DE_0000_0000_00A1, 0, 2, 5'b00010, 0, 0, Z80);
        add(0, 1, 1, 64'hC0DE_0000_0000_00A1, 0, 2, 5'b00010, 0, 0, Z80);
        add(0, 1, 1, 64'hC0DE_0000_0000_00A1, 0, 2, 0, 0, 1, fl(TT, 0, 2, 1, 64'hC0DE_0000_0000_00A1));
        idle();
        rst_vec();

        // three back-to-back 1-word messages on VC0,1,2; returns coincide with sends on VC0/VC1
        add(0, 1, 1, 64'hE000_0000_0000_0000, 1, 1, 0, 0, 0, Z80);
        add(0, 1, 1, 64'hE000_0000_0000_0000, 1, 1, 0, 0, 0, fl(TH, 1, 1, 0, HD));
        add(0, 1, 1, 64'hE000_0000_0000_0000, 1, 1, 0, 5'b00001, 1, fl(TT, 1, 1, 0, 64'hE000_0000_0000_0000));
        add(0, 1, 1, 64'hE000_0000_0000_0001, 1, 1, 0, 5'b00001, 0, Z80);
        add(0, 1, 1, 64'hE000_0000_0000_0001, 1, 1, 0, 5'b00010, 0, fl(TH, 1, 1, 1, HD));
        add(0, 1, 1, 64'hE000_0000_0000_0001, 1, 1, 0, 5'b00010, 1, fl(TT, 1, 1, 1, 64'hE000_0000_0000_0001));
        add(0, 1, 1, 64'hE000_0000_0000_0002, 1, 1, 0, 0, 0, Z80);
        add(0, 1, 1, 64'hE000_0000_0000_0002, 1, 1, 0, 0, 0, fl(TH, 1, 1, 2, HD));
        add(0, 1, 1, 64'hE000_0000_0000_0002, 1, 1, 0, 0, 1, fl(TT, 1, 1, 2, 64'hE000_0000_0000_0002));
        idle();
        // only VC1 free: eligible only if its count stayed at 4 through the simultaneous return/send
        add(0, 1, 1, 64'hE000_0000_0000_0003, 2, 2, 5'b11101, 0, 0, Z80);
        add(0, 1, 1, 64'hE000_0000_0000_0003, 2, 2, 5'b11101, 0, 0, fl(TH, 2, 2, 1, HD));
        add(0, 1, 1, 64'hE000_0000_0000_0003, 2, 2, 5'b11101, 0, 1, fl(TT, 2, 2, 1, 64'hE000_0000_0000_0003));
        // only VC0 free: back at 4 after send+return then a lone return
        add(0, 1, 1, 64'hE000_0000_0000_0004, 3, 3, 5'b11110, 0, 0, Z80);
        add(0, 1, 1, 64'hE000_0000_0000_0004, 3, 3, 5'b11110, 0, 0, fl(TH, 3, 3, 0, HD));
        add(0, 1, 1, 64'hE000_0000_0000_0004, 3, 3, 5'b11110, 0, 1, fl(TT, 3, 3, 0, 64'hE000_0000_0000_0004));
        idle();

        // out of reset: nothing emitted, not ready
        repeat (2) @(posedge clk);
        #1;
        cur = -1;
        chk80("reset_flit", flit_out, Z80);
        chk1("reset_ready", msg_if.msg_ready, 1'b0);

        run_from(0);

        // reset mid-packet: HEAD + 1 BODY, then rst between edges clears flit_out at once
        hand_start = vecs.size();
        rst_vec();
        add(0, 1, 0, 64'h6000_0000_0000_0000, 1, 2, 0, 0, 0, Z80);
        add(0, 1, 0, 64'h6000_0000_0000_0000, 1, 2, 0, 0, 0, fl(TH, 1, 2, 0, HD));
        add(0, 1, 0, 64'h6000_0000_0000_0000, 1, 2, 0, 0, 1, fl(TB, 1, 2, 0, 64'h6000_0000_0000_0000));
        run_from(hand_start);
        #2;
        rst              = 1'b1;
        msg_if.msg_valid = 1'b0;
        #1;
        cur = -2;
        chk80("async_rst_flit", flit_out, Z80);
        chk1("async_rst_ready", msg_if.msg_ready, 1'b0);

        // after reset: new message takes VC0 and sends 4 flits without stalling (credits full)
        hand_start = vecs.size();
        idle();
        add(0, 1, 0, 64'h7000_0000_0000_0000, 2, 1, 0, 0, 0, Z80);
        add(0, 1, 0, 64'h7000_0000_0000_0000, 2, 1, 0, 0, 0, fl(TH, 2, 1, 0, HD));
        add(0, 1, 0, 64'h7000_0000_0000_0000, 2, 1, 0, 0, 1, fl(TB, 2, 1, 0, 64'h7000_0000_0000_0000));
        add(0, 1, 0, 64'h7000_0000_0000_0001, 2, 1, 0, 0, 1, fl(TB, 2, 1, 0, 64'h7000_0000_0000_0001));
        add(0, 1, 1, 64'h7000_0000_0000_0002, 2, 1, 0, 0, 1, fl(TT, 2, 1, 0, 64'h7000_0000_0000_0002));
        // second 3-word message goes to VC1
        add(0, 1, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, Z80);
        add(0, 1, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, fl(TH, 0, 0, 1, HD));
        add(0, 1, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 1, fl(TB, 0, 0, 1, 64'h8000_0000_0000_0000));
        add(0, 1, 0, 64'h8000_0000_0000_0001, 0, 0, 0, 0, 1, fl(TB, 0, 0, 1, 64'h8000_0000_0000_0001));
        add(0, 1, 1, 64'h8000_0000_0000_0002, 0, 0, 0, 0, 1, fl(TT, 0, 0, 1, 64'h8000_0000_0000_0002));
        idle();
        run_from(hand_start);

`ifdef NI_INJ_STATS_EN
        // two 3-word messages since the last reset: 2 packets, 2 x 4 flits
        cur = -3;
        n_cmp++;
        if (pkt_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL pkt_cnt: got %0d want 2", pkt_cnt);
        end
        n_cmp++;
        if (flit_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL flit_cnt: got %0d want 8", flit_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
